pad_input_sampler: RTL



---
 rtl/pad_input_sampler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pad_input_sampler.sv
// pad_input_sampler
//   Read side of the GPIO pad path. Each pad's received value is
//   synchronised into clk_i, optionally debounced, and then edge-detected.
//   A qualified edge sets a sticky per-pad status bit.
//
// Optional feature macro: PAD_INPUT_SAMPLER_DEBOUNCE_EN
//   defined   : per-pad stability counters gate every data_o update
//   undefined : no counters; data_o follows the synchroniser every edge
//
// Ports
//   clk_i          SoC clock
//   rst_i          synchronous active-high reset
//   pad_in_i       raw pad receive values (async to clk_i)
//   pad_oen_i      1 = pad is an input; only input pads may raise status
//   debounce_cnt_i stability threshold D shared by all pads
//   rise_en_i      per-pad rising-edge enable
//   fall_en_i      per-pad falling-edge enable
//   irq_clr_i      per-pad single-cycle status clear
//   data_o         conditioned pad value
//   irq_status_o   sticky edge flags
//   irq_o          OR of irq_status_o

// Per-pad lane: synchroniser, optional debounce, edge detect, sticky status.
module pad_input_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pad_i,
  input  logic                  oen_i,
  input  logic                  rise_en_i,
  input  logic                  fall_en_i,
  input  logic                  clr_i,
  input  logic [DEBOUNCE_W-1:0] dcnt_i,
  output logic                  data_o,
  output logic                  status_o
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_data;
  logic                   r_status;
  logic                   w_sync;
  logic                   w_upd;
  logic                   w_rise;
  logic                   w_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PAD_INPUT_SAMPLER_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] r_cnt;

  // >= rather than == so that lowering the threshold mid-count still
  // lets the pending value through on the next edge.
  assign w_upd = (w_sync != r_data) && (r_cnt >= dcnt_i);

  // Counter restarts whenever sync agrees with data (glitch reverted) or
  // an update is taken. It cannot wrap: the compare fires at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i)                 r_cnt <= '0;
    else if (w_sync == r_data) r_cnt <= '0;
    else if (w_upd)            r_cnt <= '0;
    else                       r_cnt <= r_cnt + 1'b1;
  end
`else
  logic w_unused_dcnt;
  assign w_unused_dcnt = ^dcnt_i;
  assign w_upd         = (w_sync != r_data);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i)      r_data <= 1'b0;
    else if (w_upd) r_data <= w_sync;
  end

  // Edges exist only on update events; output-mode pads still read back
  // through r_data but never qualify.
  assign w_rise = w_upd &  w_sync & oen_i & rise_en_i;
  assign w_fall = w_upd & ~w_sync & oen_i & fall_en_i;

  // Set has priority over a coincident clear.
  always_ff @(posedge clk_i) begin
    if (rst_i)                r_status <= 1'b0;
    else if (w_rise | w_fall) r_status <= 1'b1;
    else if (clr_i)           r_status <= 1'b0;
  end

  assign data_o   = r_data;
  assign status_o = r_status;
endmodule

module pad_input_sampler #(
  parameter int NUM_PADS    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_PADS-1:0]   pad_in_i,
  input  logic [NUM_PADS-1:0]   pad_oen_i,
  input  logic [DEBOUNCE_W-1:0] debounce_cnt_i,
  input  logic [NUM_PADS-1:0]   rise_en_i,
  input  logic [NUM_PADS-1:0]   fall_en_i,
  input  logic [NUM_PADS-1:0]   irq_clr_i,
  output logic [NUM_PADS-1:0]   data_o,
  output logic [NUM_PADS-1:0]   irq_status_o,
  output logic                  irq_o
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end

  logic [NUM_PADS-1:0] w_data;
  logic [NUM_PADS-1:0] w_status;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_lane
    pad_input_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .pad_i     (pad_in_i[i]),
      .oen_i     (pad_oen_i[i]),
      .rise_en_i (rise_en_i[i]),
      .fall_en_i (fall_en_i[i]),
      .clr_i     (irq_clr_i[i]),
      .dcnt_i    (debounce_cnt_i),
      .data_o    (w_data[i]),
      .status_o  (w_status[i])
    );
  end

  assign data_o       = w_data;
  assign irq_status_o = w_status;
  // Register-only fan-in, so no combinational glitches.
  assign irq_o        = |w_status;
endmodule
